dino_jump_ctrl: RTL and testbench
=================================

Name: dino_jump_ctrl

Overview:
Per-frame jump physics for the dino sprite. It consumes the frame-end pulse and the up/down buttons, runs a ground/rise/fall/dead state machine, and drives the dino_x/dino_y coordinates consumed by the VGA display stage. It freezes on game_over, which is fed back from the display stage's collision flop.

Parameters:
GROUND_Y, 275, dino top-left y when standing (ground line 335 minus 60-pixel sprite)
DINO_X, 50, fixed dino top-left x
TOP_Y, 10, minimum allowed y (upper border)
JUMP_V0, 14, initial upward velocity, pixels/frame
GRAVITY, 1, velocity change per frame
FAST_FALL, 3, extra downward acceleration per frame while down is held in FALL
MAX_FALL_V, 20, downward velocity cap

Ports:
clk  input  1  100 MHz system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
frame_tick  input  1  frame-end pulse (screenEnd), high for several clk cycles
up  input  1  jump button, level
down  input  1  duck/fast-fall button, level
game_over  input  1  collision flag; sticky until reset
dino_x  output  32  sprite x, constant DINO_X, zero-extended
dino_y  output  32  sprite y, zero-extended from 10-bit internal register
airborne  output  1  high in RISE or FALL
state  output  2  IDLE=0, RISE=1, FALL=2, DEAD=3

Behaviour:
- Reset (async): state=IDLE, y=GROUND_Y, vel=0, jump_req=0, tick_d=0.
- Reset outputs: dino_x=DINO_X, dino_y=GROUND_Y, airborne=0, state=0.
- Edge detect: tick = frame_tick & ~tick_d; tick_d <= frame_tick every clk. Exactly one update per frame_tick rising edge. Registers update on the clk edge where tick=1, so outputs change 1 clk after the detected rise.
- jump_req: set on any clk with up=1, so a press between frames is not lost. Cleared on every tick and in DEAD. Set and clear in the same cycle: clear wins; up still high re-sets it next cycle.
- Internal widths: y is 10-bit unsigned. vel is 8-bit unsigned magnitude; direction is implied by state. All compares are unsigned, and each is evaluated before the subtraction so no wrap-around occurs.
- IDLE, on tick: if jump_req, y <= GROUND_Y-JUMP_V0, vel <= JUMP_V0-GRAVITY, go to RISE. Otherwise hold.
- RISE, on tick:
  - If down=1: go to FALL with vel=0, y unchanged (jump cut).
  - Else if y-vel < TOP_Y (tested as y < TOP_Y+vel): y <= TOP_Y, vel <= 0, go to FALL.
  - Else: y <= y-vel, vel <= vel-GRAVITY. If the result is 0 (or vel ≤ GRAVITY), vel <= 0 and go to FALL.
- FALL, on tick:
  - v' = min(vel+GRAVITY+(down?FAST_FALL:0), MAX_FALL_V).
  - If y+v' ≥ GROUND_Y: y <= GROUND_Y, vel <= 0, go to IDLE. Landing never overshoots.
  - Else: y <= y+v', vel <= v'.
- Landing tick does not consume a pending jump. A new jump starts on the next tick with jump_req set.
- game_over=1 in any non-DEAD state: go to DEAD on the next clk regardless of tick. y and vel are frozen and jump_req is cleared. DEAD exits only via reset.
- game_over and tick in the same cycle: DEAD wins and no position update occurs.
- frame_tick held high: one update only. A tick at reset deassertion is ignored if tick_d was already 1.
- airborne = (state==RISE)|(state==FALL), combinational from the state register.

Test Plan:
- Reset mid-FALL (y=200): assert reset -> same cycle dino_y=275, state=0, airborne=0; after release, with no up, y stays 275 for 10 ticks.
- up pulsed 1 clk between frames, defaults -> next tick y=261, state=RISE. After 14 ticks y=170 (apex), state=FALL. Fall y=171,173,176,…; landing at tick 28 with y=275, state=IDLE, airborne=0.
- Jump cut: down=1 on 3rd rise tick (y=248) -> state=FALL, y=248. Next tick (down held) vel=4, y=252. Then 8, 12, 16, 20, capped at 20 thereafter; y clamps to 275 on landing.
- frame_tick held high 4 clk, 10 frames, no buttons -> exactly 10 evaluations; y unchanged at 275, state IDLE.
- game_over=1 at y=200 in RISE, coincident with tick -> next clk state=3, y=200. Further ticks and up presses leave y=200. Reset returns to y=275, IDLE.
- TOP_Y=200, JUMP_V0=14 -> rising ticks give 261,248,236,225,215,206; on the 7th tick 206-8 < 200 -> y=200, state=FALL, vel=0. Next tick y=201.

Source files
------------

// File: rtl/dino_jump_ctrl.sv
// Per-frame jump physics for the dino sprite.
// | state | meaning                                  |
// | IDLE  | standing on the ground, waiting for jump |
// | RISE  | moving up, speed decays by GRAVITY       |
// | FALL  | moving down, speed grows up to cap       |
// | DEAD  | frozen after collision, left by reset    |
module dino_jump_ctrl #(
  parameter int GROUND_Y   = 275,
  parameter int DINO_X     = 50,
  parameter int TOP_Y      = 10,
  parameter int JUMP_V0    = 14,
  parameter int GRAVITY    = 1,
  parameter int FAST_FALL  = 3,
  parameter int MAX_FALL_V = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        up,
  input  logic        down,
  input  logic        game_over,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        airborne,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_FALL = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [9:0] r_y, w_y_nxt;
  logic [7:0] r_vel, w_vel_nxt;
  logic       r_jump_req, w_req_nxt;
  logic       r_tick_d;

  logic        w_tick;
  logic [10:0] w_top_lim;
  logic [7:0]  w_vel_dec;
  logic [8:0]  w_fall_raw;
  logic [7:0]  w_fall_v;
  logic [10:0] w_fall_y;

  assign w_tick     = frame_tick & ~r_tick_d;
  // Upper-border test is done as y < TOP_Y + vel so nothing wraps below zero.
  assign w_top_lim  = 11'(TOP_Y) + {3'b000, r_vel};
  assign w_vel_dec  = r_vel - 8'(GRAVITY);
  assign w_fall_raw = {1'b0, r_vel} + 9'(GRAVITY) + (down ? 9'(FAST_FALL) : 9'd0);
  assign w_fall_v   = (w_fall_raw > 9'(MAX_FALL_V)) ? 8'(MAX_FALL_V) : w_fall_raw[7:0];
  assign w_fall_y   = {1'b0, r_y} + {3'b000, w_fall_v};

  // State, position, speed and latched jump request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_y        <= 10'(GROUND_Y);
      r_vel      <= 8'd0;
      r_jump_req <= 1'b0;
      r_tick_d   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_y        <= w_y_nxt;
      r_vel      <= w_vel_nxt;
      r_jump_req <= w_req_nxt;
      r_tick_d   <= frame_tick;
    end
  end

  // Next-state physics; collision takes priority over any frame update.
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_vel_nxt   = r_vel;
    w_req_nxt   = r_jump_req | up;
    if (r_state == S_DEAD) begin
      w_req_nxt = 1'b0;
    end else if (game_over) begin
      w_state_nxt = S_DEAD;
      w_req_nxt   = 1'b0;
    end else if (w_tick) begin
      w_req_nxt = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_jump_req) begin
            w_y_nxt     = 10'(GROUND_Y - JUMP_V0);
            w_vel_nxt   = 8'(JUMP_V0 - GRAVITY);
            w_state_nxt = S_RISE;
          end
        end
        S_RISE: begin
          if (down) begin
            w_vel_nxt   = 8'd0;
            w_state_nxt = S_FALL;
          end else if ({1'b0, r_y} < w_top_lim) begin
            w_y_nxt     = 10'(TOP_Y);
            w_vel_nxt   = 8'd0;
            w_state_nxt = S_FALL;
          end else begin
            w_y_nxt = r_y - {2'b00, r_vel};
            if (r_vel <= 8'(GRAVITY)) begin
              w_vel_nxt   = 8'd0;
              w_state_nxt = S_FALL;
            end else begin
              w_vel_nxt = w_vel_dec;
            end
          end
        end
        S_FALL: begin
          if (w_fall_y >= 11'(GROUND_Y)) begin
            w_y_nxt     = 10'(GROUND_Y);
            w_vel_nxt   = 8'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_y_nxt   = w_fall_y[9:0];
            w_vel_nxt = w_fall_v;
          end
        end
        default: ;
      endcase
    end
  end

  assign dino_x   = 32'(DINO_X);
  assign dino_y   = {22'd0, r_y};
  assign airborne = (r_state == S_RISE) | (r_state == S_FALL);
  assign state    = r_state;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: directed plan scenarios plus random frames,
// two instances (default border and TOP_Y=200) checked every clock.
module tb_dino_jump_ctrl;
  logic        clk = 1'b0;
  logic        reset, frame_tick, up, down, game_over;
  logic [31:0] x1, y1, x2, y2;
  logic        ab1, ab2;
  logic [1:0]  st1, st2;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  dino_jump_ctrl dut1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
    .game_over(game_over), .dino_x(x1), .dino_y(y1), .airborne(ab1), .state(st1)
  );

  dino_jump_ctrl #(.TOP_Y(200)) dut2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
    .game_over(game_over), .dino_x(x2), .dino_y(y2), .airborne(ab2), .state(st2)
  );

  // Reference: st 0 ground, 1 rising, 2 falling, 3 dead; speed as a signed int.
  typedef struct {
    int st;
    int y;
    int vel;
    bit req;
    bit td;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.y = 275; r.vel = 0; r.req = 0; r.td = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, bit ft, bit u, bit d, bit go, int top);
    mdl_t n;
    bit   tick;
    int   ny;
    int   v;
    n    = m;
    tick = ft && !m.td;
    n.td = ft;
    if (m.st == 3 || go) begin
      n.st  = 3;
      n.req = 0;
      return n;
    end
    n.req = tick ? 1'b0 : (m.req || u);
    if (!tick) return n;
    if (m.st == 0) begin
      if (m.req) begin
        n.y = 275 - 14; n.vel = 13; n.st = 1;
      end
    end else if (m.st == 1) begin
      ny = m.y - m.vel;
      if (d) begin
        n.vel = 0; n.st = 2;
      end else if (ny < top) begin
        n.y = top; n.vel = 0; n.st = 2;
      end else begin
        n.y   = ny;
        n.vel = m.vel - 1;
        if (n.vel <= 0) begin
          n.vel = 0; n.st = 2;
        end
      end
    end else begin
      v = m.vel + 1 + (d ? 3 : 0);
      if (v > 20) v = 20;
      if (m.y + v >= 275) begin
        n.y = 275; n.vel = 0; n.st = 0;
      end else begin
        n.y = m.y + v; n.vel = v;
      end
    end
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] obs, int exp);
    n_total++;
    assert (obs === 32'(exp)) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_models();
    check("y_top10", y1, m1.y);
    check("state_top10", {30'd0, st1}, m1.st);
    check("air_top10", {31'd0, ab1}, (m1.st == 1 || m1.st == 2) ? 1 : 0);
    check("y_top200", y2, m2.y);
    check("state_top200", {30'd0, st2}, m2.st);
    check("air_top200", {31'd0, ab2}, (m2.st == 1 || m2.st == 2) ? 1 : 0);
    check("x", x1, 50);
  endtask

  task automatic cyc(bit ft, bit u, bit d, bit go);
    @(negedge clk);
    frame_tick = ft; up = u; down = d; game_over = go;
    m1 = step(m1, ft, u, d, go, 10);
    m2 = step(m2, ft, u, d, go, 200);
    @(posedge clk);
    #1;
    check_models();
  endtask

  task automatic frame(bit d);
    cyc(1'b1, 1'b0, d, 1'b0);
    cyc(1'b1, 1'b0, d, 1'b0);
    cyc(1'b0, 1'b0, d, 1'b0);
    cyc(1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic press();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    frame_tick = 0; up = 0; down = 0; game_over = 0;
    reset = 1;
    m1 = mreset();
    m2 = mreset();
    #1;
    check("rst_y", y1, 275);
    check("rst_state", {30'd0, st1}, 0);
    check("rst_air", {31'd0, ab1}, 0);
    check_models();
    @(negedge clk);
    reset = 0;
  endtask

  int hi, lo, guard;

  initial begin
    reset = 1; frame_tick = 0; up = 0; down = 0; game_over = 0;
    m1 = mreset();
    m2 = mreset();
    repeat (2) @(negedge clk);
    do_reset();

    // Full jump; second instance clamps at its 200 border on the 7th tick.
    press();
    for (int i = 0; i < 14; i++) begin
      frame(1'b0);
      if (i == 0) check("first_tick_y", y1, 261);
      if (i == 6) begin
        check("border_clamp_y", y2, 200);
        check("border_clamp_st", {30'd0, st2}, 2);
      end
      if (i == 7) check("border_next_y", y2, 201);
    end
    check("apex_y", y1, 170);
    check("apex_state", {30'd0, st1}, 2);
    for (int i = 0; i < 14; i++) frame(1'b0);
    check("land_y", y1, 275);
    check("land_state", {30'd0, st1}, 0);
    check("land_air", {31'd0, ab1}, 0);

    // Jump cut with fast fall.
    press();
    frame(1'b0);
    frame(1'b0);
    check("pre_cut_y", y1, 248);
    frame(1'b1);
    check("cut_y", y1, 248);
    check("cut_state", {30'd0, st1}, 2);
    frame(1'b1);
    check("ff_y", y1, 252);
    guard = 0;
    while (st1 != 2'd0 && guard < 20) begin
      frame(1'b1);
      guard++;
    end
    check("ff_land_y", y1, 275);
    check("ff_land_bounded", guard < 20 ? 32'd1 : 32'd0, 1);

    // Held frame_tick: one update per rising edge.
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < 8; c++) cyc(c < 4, 1'b0, 1'b0, 1'b0);
    end
    check("held_idle_y", y1, 275);
    press();
    for (int c = 0; c < 8; c++) cyc(c < 4, 1'b0, 1'b0, 1'b0);
    check("held_one_update", y1, 261);

    // Reset mid-fall, then idle frames.
    for (int i = 0; i < 16; i++) frame(1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) frame(1'b0);
    check("post_rst_idle", y1, 275);

    // Collision coincident with a tick during rise.
    press();
    for (int i = 0; i < 6; i++) frame(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("dead_state", {30'd0, st1}, 3);
    check("dead_y", y1, 206);
    for (int i = 0; i < 4; i++) begin
      press();
      frame(1'b0);
    end
    check("dead_frozen_y", y1, 206);
    do_reset();

    // Random frames with occasional collisions and resets.
    for (int f = 0; f < 300; f++) begin
      hi = $urandom_range(1, 4);
      lo = $urandom_range(2, 6);
      if (f % 75 == 74) do_reset();
      for (int c = 0; c < hi + lo; c++)
        cyc(c < hi, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 599) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
